// File: rtl/mult_div_if.sv
// mult_div_if: bundles the request, abort, HI/LO write and result signals
// exchanged between the datapath and the multiply/divide unit.
//   master (datapath): drives start/op/a/b/abort/wr_hi/wr_lo/wdat,
//                      observes busy/done/hi/lo
//   slave  (unit)    : the reverse
interface mult_div_if #(
  parameter int WORD_W = 32
) ();
  logic              start;
  logic [1:0]        op;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              abort;
  logic              wr_hi;
  logic              wr_lo;
  logic [WORD_W-1:0] wdat;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

  modport master (
    output start, op, a, b, abort, wr_hi, wr_lo, wdat,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, wr_hi, wr_lo, wdat,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both work on
// operand magnitudes, one bit per cycle over WORD_W cycles, and a final
// FIX cycle applies the sign correction.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - mult_div_if.slave:
//          start/op/a/b   request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//          abort          squash the in-flight operation
//          wr_hi/wr_lo/wdat MTHI/MTLO writes, honoured in IDLE and DONE
//          busy/done      status; done is a one-cycle pulse
//          hi/lo          architectural HI/LO registers
module mult_div_unit #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input logic       CLK,
  input logic       nRST,
  mult_div_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_W);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WORD_W-1:0]   a_q, a_d;      // original operands, kept for divide-by-zero
  logic [WORD_W-1:0]   b_q, b_d;
  logic [WORD_W-1:0]   opnd_q, opnd_d;  // |a| for multiply, |b| for divide
  logic [2*WORD_W-1:0] acc_q, acc_d;    // product, or dividend/quotient in low half
  logic [WORD_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                qneg_q, qneg_d;  // negate product/quotient
  logic                rneg_q, rneg_d;  // negate remainder
  logic [WORD_W-1:0]   hi_q, hi_d;
  logic [WORD_W-1:0]   lo_q, lo_d;

  logic [WORD_W-1:0] mag_a, mag_b;
  logic [WORD_W:0]   sum, addend, shifted, diff;
  logic              is_signed;

  function automatic logic [WORD_W-1:0] mag(input logic signed [WORD_W-1:0] v);
    return v[WORD_W-1] ? -v : v;
  endfunction

  function automatic logic [WORD_W-1:0] neg_w(input logic [WORD_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WORD_W-1:0] neg_acc(input logic [2*WORD_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    is_signed = ~op_q[0];
    mag_a     = is_signed ? mag(a_q) : a_q;
    mag_b     = is_signed ? mag(b_q) : b_q;
    addend    = acc_q[0] ? {1'b0, opnd_q} : {(WORD_W+1){1'b0}};
    sum       = {1'b0, acc_q[2*WORD_W-1:WORD_W]} + addend;
    shifted   = {rem_q, acc_q[WORD_W-1]};
    // Borrow out of the W+1 bit trial subtraction means divisor did not fit.
    diff      = shifted - {1'b0, opnd_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wdat;
        if (bus.wr_lo) lo_d = bus.wdat;
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          qneg_d = is_signed & (a_q[WORD_W-1] ^ b_q[WORD_W-1]);
          rneg_d = is_signed & a_q[WORD_W-1];
          if (op_q[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WORD_W{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WORD_W{1'b0}}, mag_b};
          end
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            rem_d = diff[WORD_W] ? shifted[WORD_W-1:0] : diff[WORD_W-1:0];
            acc_d = {acc_q[2*WORD_W-1:WORD_W], acc_q[WORD_W-2:0], ~diff[WORD_W]};
          end else begin
            acc_d = {sum, acc_q[WORD_W-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 1) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            if (b_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rneg_q ? neg_w(rem_q) : rem_q;
              lo_d = qneg_q ? neg_w(acc_q[WORD_W-1:0]) : acc_q[WORD_W-1:0];
            end
          end else begin
            {hi_d, lo_d} = qneg_q ? neg_acc(acc_q) : acc_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A write here lands after the FIX result and therefore wins.
        if (bus.wr_hi) hi_d = bus.wdat;
        if (bus.wr_lo) lo_d = bus.wdat;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit (WORD_W=32): directed operations push their
// expected {hi,lo} into a queue; a monitor pops and compares on each done.
module tb_mult_div_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mult_div_if #(.WORD_W(W)) bus ();
  mult_div_unit #(.WORD_W(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1 && bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'd0, bus.done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi", {32'd0, bus.hi}, {32'd0, e[2*W-1:W]});
          check("lo", {32'd0, bus.lo}, {32'd0, e[W-1:0]});
        end
      end
    end
  end

  // Issues a start; returns just after the edge that sampled it.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) exp_q.push_back({eh, el});
    @(posedge CLK);
    #1 bus.start = 1'b0;
  endtask

  // n = edges after the sampling edge before done is seen; bc = busy cycles.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) bc++;
      @(posedge CLK);
      n++;
    end
    check("done_seen", {63'd0, bus.done}, 64'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int n, bc;
    start_op(op, a, b, 1'b1, eh, el);
    wait_done(n, bc);
    // done is sampled high at edge n+1 after the start edge
    check("latency", 64'(n + 1), 64'(W + 3));
    check("busy_cycles", 64'(bc), 64'(W + 2));
  endtask

  task automatic write_reg(input bit h, input bit l, input logic [W-1:0] d);
    @(negedge CLK);
    bus.wr_hi = h;
    bus.wr_lo = l;
    bus.wdat  = d;
    @(posedge CLK);
    #1;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
  endtask

  initial begin
    int n, bc;
    nRST      = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.abort = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdat  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    run_op(2'b00, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(2'b00, 32'h0000_1234, 32'h0001_0000, 32'h0000_0000, 32'h1234_0000);
    run_op(2'b11, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Abort in ITER cycle 10, with a stray start during ITER beforehand.
    start_op(2'b00, 32'd3, 32'd4, 1'b0, '0, '0);
    repeat (5) @(posedge CLK);
    #1 bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("busy_before_abort", {63'd0, bus.busy}, 64'd1);
    bus.abort = 1'b1;
    @(posedge CLK);
    #1 bus.abort = 1'b0;
    @(negedge CLK);
    check("busy_after_abort", {63'd0, bus.busy}, 64'd0);
    repeat (50) @(negedge CLK);
    check("abort_hi", {32'd0, bus.hi}, {32'd0, 32'hFFFF_FFF0});
    check("abort_lo", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFF});

    // MTHI in IDLE
    write_reg(1'b1, 1'b0, 32'h0000_1234);
    @(negedge CLK);
    check("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h0000_1234});
    check("mthi_lo", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFF});

    // MTLO during ITER is ignored; the operation still completes.
    start_op(2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    repeat (3) @(posedge CLK);
    #1;
    bus.wr_lo = 1'b1;
    bus.wdat  = 32'h0000_DEAD;
    @(posedge CLK);
    #1 bus.wr_lo = 1'b0;
    @(negedge CLK);
    check("mtlo_iter_lo", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFF});
    wait_done(n, bc);

    // Reset mid-ITER clears everything immediately.
    write_reg(1'b1, 1'b0, 32'h0000_ABCD);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, '0);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    nRST = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_hi", {32'd0, bus.hi}, 64'd0);
    check("mid_rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (45) @(negedge CLK);
    check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the next-generation datapath and adds MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO support.
- Runs as a multi-cycle FSM. The datapath stalls its PC and register-file write-enable while busy=1.
- Word width is a parameter, so the same block serves 32- and 64-bit datapath builds.

Parameters:
- WORD_W, 32: operand, HI and LO width in bits; must be an even number ≥ 4.
- CNT_W, $clog2(WORD_W)+1: iteration counter width; derived, do not override.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WORD_W  multiplicand or dividend (rs).
- b  in  WORD_W  multiplier or divisor (rt).
- abort  in  1  squash the in-flight operation (pipeline flush).
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdat  in  WORD_W  MTHI/MTLO write data.
- busy  out  1  high from the cycle after start is accepted through the FIX state.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WORD_W  HI register (product upper half / remainder).
- lo  out  WORD_W  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, nRST=0): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches op, a and b; next state PREP.
  - start=0 holds IDLE.
- PREP (1 cycle):
  - Signed ops: store |a| and |b|, record sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Unsigned ops: pass a and b through with both signs cleared.
  - Load counter = WORD_W; next state ITER.
- ITER (exactly WORD_W cycles, counter decrements each cycle):
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WORD_W accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter reaching 1 advances to FIX.
- FIX (1 cycle):
  - Apply sign correction: negate the product if sign_q; negate the quotient if sign_q; negate the remainder if sign_r.
  - Write hi/lo; next state DONE.
- DONE (1 cycle): done=1, busy=0; next state IDLE. start is not accepted in DONE.
- Latency: done is high exactly WORD_W+3 rising edges after the edge that sampled start. busy=1 during PREP, ITER and FIX.
- Arithmetic rules:
  - Multiply: {hi,lo} = full 2*WORD_W-bit product, two's complement for MULT.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (DIV or DIVU, b=0): ITER still runs the full count; result hi=a (original, unmodified), lo=all ones. No exception is raised.
- Signed overflow (DIV, a = most-negative value, b = all ones): lo = most-negative value, hi = 0. This falls out of the unsigned-magnitude method; no special-case path.
- start while not IDLE: ignored, no queueing.
- abort:
  - In PREP, ITER or FIX: next state IDLE, hi/lo unchanged, no done pulse.
  - In IDLE or DONE: no effect. A done pulse already in DONE still completes.
- wr_hi/wr_lo:
  - Honoured in IDLE and DONE only: register written at the next edge.
  - Ignored in PREP, ITER and FIX; the datapath guarantees stall.
  - A write in DONE overrides the just-written result for that register.
- start together with wr_hi/wr_lo in IDLE: the write occurs and the operation starts. The operation later overwrites both registers in FIX.
- Reset asserted mid-operation: immediate return to the reset state; hi/lo cleared.
- Internal widths: accumulator 2*WORD_W bits; divider partial remainder WORD_W+1 bits.

Test Plan:
- Reset, then a=5, b=0xFFFFFFFD, op=MULT (WORD_W=32) -> done at edge 35; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for cycles 1–34.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, normal latency. DIV a=0xFFFFFFF0, b=0 -> hi=0xFFFFFFF0, lo=0xFFFFFFFF.
- Start MULT, assert abort in ITER cycle 10 -> busy drops next edge, no done, hi/lo keep prior values. A second start pulse during ITER is ignored.
- In IDLE, wr_hi=1, wdat=0x1234 -> hi=0x1234. wr_lo during ITER -> lo unchanged. nRST pulsed mid-ITER -> busy=0, hi=lo=0 immediately.
